// File: rtl/md5_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : md5_sched_if
// Purpose  : Bundles the parser-side byte stream/result signals and the
//            hash-unit dispatch/result signals of md5_sched.
// Modports : slave  - the scheduler (consumes stream, drives units/results)
//            master - the parser plus the hash-unit bank
// Revision : 1.0 - initial release
// ============================================================================
interface md5_sched_if #(
    parameter int NUM_UNITS = 4,
    parameter int STR_LEN   = 19
);
    logic                   proc_start;
    logic [15:0]            proc_num_bytes;
    logic [7:0]             proc_data;
    logic                   proc_data_valid;
    logic                   proc_match_char_next;
    logic                   proc_done;
    logic                   proc_match;
    logic [15:0]            proc_byte_pos;
    logic [7:0]             proc_match_char;
    logic                   overrun;
    logic [NUM_UNITS-1:0]   unit_start;
    logic [8*STR_LEN-1:0]   unit_window;
    logic [NUM_UNITS-1:0]   unit_busy;
    logic [NUM_UNITS-1:0]   unit_done;
    logic [NUM_UNITS-1:0]   unit_match;

    modport slave (
        input  proc_start, proc_num_bytes, proc_data, proc_data_valid,
               proc_match_char_next, unit_busy, unit_done, unit_match,
        output proc_done, proc_match, proc_byte_pos, proc_match_char,
               overrun, unit_start, unit_window
    );

    modport master (
        output proc_start, proc_num_bytes, proc_data, proc_data_valid,
               proc_match_char_next, unit_busy, unit_done, unit_match,
        input  proc_done, proc_match, proc_byte_pos, proc_match_char,
               overrun, unit_start, unit_window
    );
endinterface
`default_nettype wire

// File: rtl/md5_sched.sv
`default_nettype none
// ============================================================================
// Module   : md5_sched
// Purpose  : Slides a STR_LEN-byte window over the parser byte stream, issues
//            every complete window to a free MD5 unit in round-robin order,
//            and keeps the lowest-position matching candidate.
// Ports    : clk     - system clock
//            reset_n - asynchronous active-low reset
//            bus     - md5_sched_if.slave (parser stream/results, unit
//                      start/window, unit busy/done/match)
// Revision : 1.0 - initial release
// ============================================================================
module md5_sched #(
    parameter int NUM_UNITS = 4,
    parameter int STR_LEN   = 19
) (
    input  wire logic       clk,
    input  wire logic       reset_n,
    md5_sched_if.slave      bus
);
    localparam int c_PW = $clog2(NUM_UNITS);
    localparam int c_IW = $clog2(STR_LEN);
    localparam int c_WW = 8 * STR_LEN;

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_RUN   = 2'd1;
    localparam logic [1:0] c_S_DRAIN = 2'd2;
    localparam logic [1:0] c_S_DONE  = 2'd3;

    logic [1:0]             r_state;
    logic [15:0]            r_num_bytes;
    logic [15:0]            r_cnt;
    logic [c_WW-1:0]        r_win;
    logic                   r_pending;
    logic [15:0]            r_pend_tag;
    logic [NUM_UNITS-1:0]   r_inflight;
    logic [c_PW-1:0]        r_ptr;
    logic [NUM_UNITS-1:0]   r_unit_start;
    logic [c_WW-1:0]        r_unit_window;
    logic [15:0]            r_tag [NUM_UNITS];
    logic [c_WW-1:0]        r_str [NUM_UNITS];
    logic                   r_match;
    logic [15:0]            r_pos;
    logic [c_WW-1:0]        r_mstr;
    logic [c_IW-1:0]        r_idx;
    logic                   r_overrun;

    logic                   w_byte;
    logic [15:0]            w_cnt_inc;
    logic                   w_new_cand;
    logic [15:0]            w_new_tag;
    logic [NUM_UNITS-1:0]   w_free;
    logic                   w_disp;
    logic [c_PW-1:0]        w_sel;
    logic [c_PW-1:0]        w_sel_next;
    logic [NUM_UNITS-1:0]   w_sel_oh;
    int                     w_rr_int;
    logic [c_PW-1:0]        w_rr_idx;
    logic [NUM_UNITS-1:0]   w_ret;
    logic                   w_hit;
    logic [15:0]            w_hit_tag;
    logic [c_WW-1:0]        w_hit_str;
    logic                   w_take;
    logic [7:0]             w_char;

    assign w_byte     = bus.proc_data_valid && (r_state == c_S_RUN);
    assign w_cnt_inc  = r_cnt + 16'd1;
    assign w_new_cand = w_byte && (w_cnt_inc >= 16'(STR_LEN));
    assign w_new_tag  = w_cnt_inc - 16'(STR_LEN);
    assign w_free     = ~bus.unit_busy & ~r_inflight;
    assign w_ret      = bus.unit_done & r_inflight;

    // First free unit at or above the round-robin pointer, wrapping around.
    always_comb begin
        w_disp   = 1'b0;
        w_sel    = '0;
        w_rr_int = 0;
        w_rr_idx = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            w_rr_int = int'(r_ptr) + k;
            if (w_rr_int >= NUM_UNITS) begin
                w_rr_int = w_rr_int - NUM_UNITS;
            end
            w_rr_idx = c_PW'(w_rr_int);
            if (!w_disp && w_free[w_rr_idx]) begin
                w_disp = 1'b1;
                w_sel  = w_rr_idx;
            end
        end
        w_disp = w_disp && r_pending && !bus.proc_start;
    end

    assign w_sel_next = (w_sel == c_PW'(NUM_UNITS - 1)) ? '0 : w_sel + 1'b1;
    assign w_sel_oh   = w_disp ? (NUM_UNITS'(1) << w_sel) : '0;

    // Lowest tag among all matching results on this edge; results from
    // units that are not in flight belong to an aborted job.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_tag = '0;
        w_hit_str = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (w_ret[i] && bus.unit_match[i] && (!w_hit || r_tag[i] < w_hit_tag)) begin
                w_hit     = 1'b1;
                w_hit_tag = r_tag[i];
                w_hit_str = r_str[i];
            end
        end
    end

    assign w_take = w_hit && (!r_match || w_hit_tag < r_pos);

    always_comb begin
        w_char = '0;
        for (int k = 0; k < STR_LEN; k++) begin
            if (r_idx == c_IW'(k)) begin
                w_char = r_mstr[8*(STR_LEN-1-k) +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= c_S_IDLE;
            r_num_bytes   <= '0;
            r_cnt         <= '0;
            r_win         <= '0;
            r_pending     <= 1'b0;
            r_pend_tag    <= '0;
            r_inflight    <= '0;
            r_ptr         <= '0;
            r_unit_start  <= '0;
            r_unit_window <= '0;
            r_match       <= 1'b0;
            r_pos         <= '0;
            r_mstr        <= '0;
            r_idx         <= '0;
            r_overrun     <= 1'b0;
        end else begin
            r_unit_start <= '0;
            if (bus.proc_start) begin
                r_num_bytes <= bus.proc_num_bytes;
                r_cnt       <= '0;
                r_pending   <= 1'b0;
                r_inflight  <= '0;
                r_match     <= 1'b0;
                r_overrun   <= 1'b0;
                r_pos       <= '0;
                r_idx       <= '0;
                r_state     <= (bus.proc_num_bytes == 16'd0) ? c_S_DRAIN : c_S_RUN;
            end else begin
                if (w_byte) begin
                    r_win <= {r_win[c_WW-9:0], bus.proc_data};
                    if (r_cnt != r_num_bytes) begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                // A new candidate wins over clearing; an undispatched old
                // one is lost.
                if (w_new_cand) begin
                    r_pending  <= 1'b1;
                    r_pend_tag <= w_new_tag;
                    if (r_pending && !w_disp) begin
                        r_overrun <= 1'b1;
                    end
                end else if (w_disp) begin
                    r_pending <= 1'b0;
                end
                if (w_disp) begin
                    r_unit_start  <= w_sel_oh;
                    r_unit_window <= r_win;
                    r_ptr         <= w_sel_next;
                end
                r_inflight <= (r_inflight & ~w_ret) | w_sel_oh;
                if (w_take) begin
                    r_match <= 1'b1;
                    r_pos   <= w_hit_tag;
                    r_mstr  <= w_hit_str;
                end
                if (bus.proc_match_char_next) begin
                    r_idx <= (r_idx == c_IW'(STR_LEN - 1)) ? '0 : r_idx + 1'b1;
                end
                case (r_state)
                    c_S_RUN: begin
                        if (w_byte && (w_cnt_inc == r_num_bytes)) begin
                            r_state <= c_S_DRAIN;
                        end
                    end
                    c_S_DRAIN: begin
                        if (!r_pending && (r_inflight == '0)) begin
                            r_state <= c_S_DONE;
                            r_idx   <= '0;
                        end
                    end
                    c_S_DONE: r_state <= c_S_IDLE;
                    default:  r_state <= c_S_IDLE;
                endcase
            end
        end
    end

    // Per-unit candidate bookkeeping; only read while the unit is in flight.
    always_ff @(posedge clk) begin
        if (w_disp) begin
            r_tag[w_sel] <= r_pend_tag;
            r_str[w_sel] <= r_win;
        end
    end

    assign bus.proc_done       = (r_state == c_S_DONE);
    assign bus.proc_match      = r_match;
    assign bus.proc_byte_pos   = r_pos;
    assign bus.proc_match_char = w_char;
    assign bus.overrun         = r_overrun;
    assign bus.unit_start      = r_unit_start;
    assign bus.unit_window     = r_unit_window;
endmodule
`default_nettype wire

// File: tb/tb_md5_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_md5_sched
// Purpose  : Self-checking bench for md5_sched with a behavioural hash-unit
//            bank (per-candidate latency and match tables) and a reference
//            model of window contents, round-robin order and lowest match.
// Revision : 1.0 - initial release
// ============================================================================
module tb_md5_sched;
    localparam int NU = 4;
    localparam int SL = 19;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    md5_sched_if #(.NUM_UNITS(NU), .STR_LEN(SL)) bus ();
    md5_sched #(.NUM_UNITS(NU), .STR_LEN(SL)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    int             n_vec = 0;
    int             n_err = 0;
    logic [7:0]     jb [0:127];
    bit             match_set [0:63];
    int             lat_tab [0:63];
    int             cd [NU];
    bit             um [NU];
    logic [NU-1:0]  busy_force = '0;
    bit             tb_clear = 1'b1;
    bit             mon_strict = 1'b0;
    int             disp_cnt = 0;
    int             rr_exp = 0;
    int             mon_u;
    int             q_unit [$];
    logic [8*SL-1:0] q_win [$];
    logic [NU-1:0]  dv, mv;
    time            last_done_t = 0;

    function automatic logic [8*SL-1:0] exp_win(input int k);
        logic [8*SL-1:0] w;
        w = '0;
        for (int j = 0; j < SL; j++) w[8*(SL-1-j) +: 8] = jb[k+j];
        return w;
    endfunction

    // Hash-unit bank: each unit answers lat_tab[tag] cycles after its start
    // with match_set[tag], and reports busy while working.
    always @(negedge clk) begin
        if (tb_clear) begin
            for (int i = 0; i < NU; i++) cd[i] = 0;
            bus.unit_done  = '0;
            bus.unit_match = '0;
            bus.unit_busy  = busy_force;
        end else begin
            dv = '0;
            mv = '0;
            for (int i = 0; i < NU; i++) begin
                if (cd[i] > 0) begin
                    cd[i]--;
                    if (cd[i] == 0) begin
                        dv[i] = 1'b1;
                        mv[i] = um[i];
                        last_done_t = $time;
                    end
                end
            end
            if (bus.unit_start != '0) begin
                n_vec++;
                if (!$onehot(bus.unit_start)) begin
                    n_err++;
                    $display("FAIL unit_start_onehot: got %b, want one bit", bus.unit_start);
                end
                mon_u = 0;
                for (int i = 0; i < NU; i++) if (bus.unit_start[i]) mon_u = i;
                q_unit.push_back(mon_u);
                q_win.push_back(bus.unit_window);
                if (mon_strict) begin
                    n_vec++;
                    if (mon_u != rr_exp) begin
                        n_err++;
                        $display("FAIL rr_unit: dispatch %0d went to unit %0d, want %0d", disp_cnt, mon_u, rr_exp);
                    end
                    n_vec++;
                    if (bus.unit_window !== exp_win(disp_cnt)) begin
                        n_err++;
                        $display("FAIL window: dispatch %0d got %h want %h", disp_cnt, bus.unit_window, exp_win(disp_cnt));
                    end
                end
                cd[mon_u] = lat_tab[disp_cnt];
                um[mon_u] = match_set[disp_cnt];
                disp_cnt++;
                rr_exp = (mon_u + 1) % NU;
            end
            bus.unit_done  = dv;
            bus.unit_match = mv;
            bus.unit_busy  = busy_force;
            for (int i = 0; i < NU; i++) if (cd[i] > 0) bus.unit_busy[i] = 1'b1;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        tb_clear = 1'b1;
        bus.proc_start = 1'b0;
        bus.proc_data_valid = 1'b0;
        bus.proc_match_char_next = 1'b0;
        busy_force = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        tb_clear = 1'b0;
        rr_exp = 0;
        disp_cnt = 0;
    endtask

    task automatic set_tables(input int lat, input bit m);
        for (int k = 0; k < 64; k++) begin
            lat_tab[k] = lat;
            match_set[k] = m;
        end
    endtask

    task automatic rand_bytes();
        for (int i = 0; i < 128; i++) jb[i] = 8'($urandom);
    endtask

    task automatic start_job(input int n);
        @(negedge clk);
        bus.proc_start = 1'b1;
        bus.proc_num_bytes = 16'(n);
        disp_cnt = 0;
        q_unit.delete();
        q_win.delete();
        @(negedge clk);
        bus.proc_start = 1'b0;
    endtask

    // Returns on the negedge of the cycle after the last byte.
    task automatic send_bytes(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            bus.proc_data_valid = 1'b1;
            bus.proc_data = jb[i];
            @(negedge clk);
            bus.proc_data_valid = 1'b0;
            repeat (gap - 1) @(negedge clk);
        end
    endtask

    task automatic wait_done(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (bus.proc_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_vec++;
        if ({bus.proc_done, bus.proc_match, bus.proc_byte_pos, bus.proc_match_char, bus.overrun, bus.unit_start} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got done=%b match=%b pos=%0d char=%h ovr=%b start=%b, want all 0",
                     bus.proc_done, bus.proc_match, bus.proc_byte_pos, bus.proc_match_char, bus.overrun, bus.unit_start);
        end
        n_vec++;
        if (bus.unit_window !== '0) begin
            n_err++;
            $display("FAIL reset_window: got %h want 0", bus.unit_window);
        end
        do_reset();
    endtask

    task automatic test_single_match();
        bit ok;
        do_reset();
        set_tables(50, 1'b0);
        match_set[0] = 1'b1;
        mon_strict = 1'b1;
        rand_bytes();
        start_job(19);
        send_bytes(19, 1);
        wait_done(200, ok);
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL single_done: no proc_done within 200 cycles, want pulse"); end
        n_vec++;
        if (q_unit.size() != 1 || q_unit[0] != 0) begin
            n_err++;
            $display("FAIL single_dispatch: got %0d dispatches, want 1 to unit 0", q_unit.size());
        end
        n_vec++;
        if (bus.proc_match !== 1'b1 || bus.proc_byte_pos !== 16'd0) begin
            n_err++;
            $display("FAIL single_result: got match=%b pos=%0d, want 1/0", bus.proc_match, bus.proc_byte_pos);
        end
        n_vec++;
        if ($time - last_done_t != 20) begin
            n_err++;
            $display("FAIL done_latency: got %0t after unit_done, want 20", $time - last_done_t);
        end
        n_vec++;
        if (bus.proc_match_char !== jb[0]) begin
            n_err++;
            $display("FAIL match_char0: got %h want %h", bus.proc_match_char, jb[0]);
        end
        for (int i = 1; i <= SL; i++) begin
            bus.proc_match_char_next = 1'b1;
            @(negedge clk);
            bus.proc_match_char_next = 1'b0;
            n_vec++;
            if (bus.proc_match_char !== jb[i % SL]) begin
                n_err++;
                $display("FAIL match_char_read: index %0d got %h want %h", i % SL, bus.proc_match_char, jb[i % SL]);
            end
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        do_reset();
        set_tables(1, 1'b0);
        mon_strict = 1'b1;
        rand_bytes();
        start_job(40);
        send_bytes(40, 1);
        wait_done(200, ok);
        n_vec++;
        if (!ok || q_unit.size() != 22) begin
            n_err++;
            $display("FAIL rr_count: done=%b dispatches=%0d, want 1/22", ok, q_unit.size());
        end
        for (int k = 0; k < q_unit.size(); k++) begin
            n_vec++;
            if (q_unit[k] != k % NU) begin
                n_err++;
                $display("FAIL rr_order: dispatch %0d unit %0d want %0d", k, q_unit[k], k % NU);
            end
        end
        n_vec++;
        if (bus.proc_match !== 1'b0 || bus.overrun !== 1'b0) begin
            n_err++;
            $display("FAIL rr_flags: got match=%b ovr=%b, want 0/0", bus.proc_match, bus.overrun);
        end
    endtask

    task automatic test_lowest_tag();
        bit ok;
        do_reset();
        set_tables(1, 1'b0);
        lat_tab[7] = 9;            // tag 7 (unit 3) finishes together with tag 9 (unit 1)
        match_set[7] = 1'b1;
        match_set[9] = 1'b1;
        match_set[12] = 1'b1;
        mon_strict = 1'b1;
        rand_bytes();
        start_job(40);
        send_bytes(40, 4);
        wait_done(300, ok);
        n_vec++;
        if (!ok || bus.proc_match !== 1'b1 || bus.proc_byte_pos !== 16'd7) begin
            n_err++;
            $display("FAIL lowest_tag: done=%b match=%b pos=%0d, want 1/1/7", ok, bus.proc_match, bus.proc_byte_pos);
        end
        n_vec++;
        if (bus.proc_match_char !== jb[7]) begin
            n_err++;
            $display("FAIL lowest_char: got %h want %h", bus.proc_match_char, jb[7]);
        end
    endtask

    task automatic test_overrun();
        bit ok;
        set_tables(3, 1'b0);
        match_set[0] = 1'b1;
        mon_strict = 1'b0;
        busy_force = '1;
        rand_bytes();
        start_job(20);
        send_bytes(20, 1);
        repeat (4) @(negedge clk);
        n_vec++;
        if (bus.overrun !== 1'b1 || q_unit.size() != 0) begin
            n_err++;
            $display("FAIL overrun_flag: ovr=%b dispatches=%0d, want 1/0", bus.overrun, q_unit.size());
        end
        busy_force = '0;
        wait_done(100, ok);
        n_vec++;
        if (!ok || q_unit.size() != 1) begin
            n_err++;
            $display("FAIL overrun_dispatch: done=%b dispatches=%0d, want 1/1", ok, q_unit.size());
        end else begin
            n_vec++;
            if (q_win[0] !== exp_win(1)) begin
                n_err++;
                $display("FAIL overrun_window: got %h want %h", q_win[0], exp_win(1));
            end
        end
        n_vec++;
        if (bus.proc_match !== 1'b1 || bus.proc_byte_pos !== 16'd1) begin
            n_err++;
            $display("FAIL overrun_tag: match=%b pos=%0d, want 1/1", bus.proc_match, bus.proc_byte_pos);
        end
    endtask

    task automatic test_short_jobs();
        rand_bytes();
        mon_strict = 1'b1;
        start_job(5);
        send_bytes(5, 1);
        n_vec++;
        if (bus.proc_done !== 1'b0) begin n_err++; $display("FAIL short_early: done=%b want 0", bus.proc_done); end
        @(negedge clk);
        n_vec++;
        if (bus.proc_done !== 1'b1 || bus.proc_match !== 1'b0 || q_unit.size() != 0) begin
            n_err++;
            $display("FAIL short_done: done=%b match=%b dispatches=%0d, want 1/0/0", bus.proc_done, bus.proc_match, q_unit.size());
        end
        start_job(0);
        n_vec++;
        if (bus.proc_done !== 1'b0) begin n_err++; $display("FAIL empty_early: done=%b want 0", bus.proc_done); end
        @(negedge clk);
        n_vec++;
        if (bus.proc_done !== 1'b1) begin n_err++; $display("FAIL empty_done: done=%b want 1", bus.proc_done); end
    endtask

    task automatic test_abort();
        bit ok;
        set_tables(25, 1'b1);
        mon_strict = 1'b1;
        rand_bytes();
        start_job(30);
        send_bytes(20, 1);
        repeat (3) @(negedge clk);
        n_vec++;
        if (q_unit.size() != 2) begin
            n_err++;
            $display("FAIL abort_inflight: got %0d dispatches, want 2", q_unit.size());
        end
        set_tables(10, 1'b0);
        rand_bytes();
        start_job(19);
        send_bytes(19, 1);
        wait_done(200, ok);
        n_vec++;
        if (!ok || bus.proc_match !== 1'b0 || q_unit.size() != 1) begin
            n_err++;
            $display("FAIL abort_newjob: done=%b match=%b dispatches=%0d, want 1/0/1", ok, bus.proc_match, q_unit.size());
        end
    endtask

    task automatic test_random();
        bit ok;
        int n, ncand, epos;
        bit em;
        mon_strict = 1'b1;
        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(10, 60);
            ncand = (n >= SL) ? n - SL + 1 : 0;
            em = 1'b0;
            epos = 0;
            for (int k = 0; k < 64; k++) begin
                lat_tab[k] = $urandom_range(1, 2);
                match_set[k] = ($urandom_range(0, 7) == 0);
                if (k < ncand && match_set[k] && !em) begin
                    em = 1'b1;
                    epos = k;
                end
            end
            rand_bytes();
            start_job(n);
            send_bytes(n, 1);
            wait_done(300, ok);
            n_vec++;
            if (!ok || q_unit.size() != ncand || bus.overrun !== 1'b0) begin
                n_err++;
                $display("FAIL rand_job: n=%0d done=%b dispatches=%0d ovr=%b, want 1/%0d/0", n, ok, q_unit.size(), bus.overrun, ncand);
            end
            n_vec++;
            if (bus.proc_match !== em || (em && bus.proc_byte_pos !== 16'(epos))) begin
                n_err++;
                $display("FAIL rand_result: n=%0d match=%b pos=%0d, want %b/%0d", n, bus.proc_match, bus.proc_byte_pos, em, epos);
            end
            if (em) begin
                n_vec++;
                if (bus.proc_match_char !== jb[epos]) begin
                    n_err++;
                    $display("FAIL rand_char: got %h want %h", bus.proc_match_char, jb[epos]);
                end
            end
        end
    endtask

    task automatic test_reset_midjob();
        set_tables(1, 1'b1);
        mon_strict = 1'b1;
        rand_bytes();
        start_job(25);
        send_bytes(22, 1);
        n_vec++;
        if (bus.proc_match !== 1'b1) begin n_err++; $display("FAIL midjob_match: got %b want 1", bus.proc_match); end
        #2 reset_n = 1'b0;
        #1;
        n_vec++;
        if ({bus.proc_done, bus.proc_match, bus.proc_byte_pos, bus.proc_match_char, bus.overrun, bus.unit_start} !== '0
            || bus.unit_window !== '0) begin
            n_err++;
            $display("FAIL midjob_reset: done=%b match=%b pos=%0d char=%h ovr=%b start=%b, want all 0",
                     bus.proc_done, bus.proc_match, bus.proc_byte_pos, bus.proc_match_char, bus.overrun, bus.unit_start);
        end
        tb_clear = 1'b1;
        bus.proc_data_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        tb_clear = 1'b0;
        rr_exp = 0;
        start_job(0);
        @(negedge clk);
        n_vec++;
        if (bus.proc_done !== 1'b1) begin n_err++; $display("FAIL post_reset_job: done=%b want 1", bus.proc_done); end
    endtask

    initial begin
        bus.proc_start = 1'b0;
        bus.proc_num_bytes = '0;
        bus.proc_data = '0;
        bus.proc_data_valid = 1'b0;
        bus.proc_match_char_next = 1'b0;
        set_tables(1, 1'b0);
        test_reset();
        test_single_match();
        test_round_robin();
        test_lowest_tag();
        test_overrun();
        test_short_jobs();
        test_abort();
        test_random();
        test_reset_midjob();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
